// File: rtl/decode_if.sv
// rtl/decode_if.sv - byte-stream in / coefficient-pair out handshake bundle for the decode block
interface decode_if;
    logic [3:0]  i_l;
    logic [63:0] i_ibytes;
    logic        i_ibytes_valid;
    logic        o_ibytes_ready;
    logic [23:0] o_coeffs;
    logic        o_coeffs_valid;
    logic        i_coeffs_ready;
    logic        o_done;

    modport slave (
        input  i_l, i_ibytes, i_ibytes_valid, i_coeffs_ready,
        output o_ibytes_ready, o_coeffs, o_coeffs_valid, o_done
    );

    modport master (
        output i_l, i_ibytes, i_ibytes_valid, i_coeffs_ready,
        input  o_ibytes_ready, o_coeffs, o_coeffs_valid, o_done
    );
endinterface

// File: rtl/decode.sv
// rtl/decode.sv - Kyber ByteDecode_l: 64-bit words in, two l-bit coefficients per beat out
// Optional DECODE_DEBUG_EN adds o_coeffs_debug holding the whole decoded polynomial.
module decode (
    input  logic            i_clk,
    input  logic            i_rst,
    decode_if.slave         bus
`ifdef DECODE_DEBUG_EN
    ,
    output logic [3071:0]   o_coeffs_debug
`endif
);
    localparam logic [11:0] Q     = 12'd3329;
    localparam int          NCOEF = 256;
    localparam logic [7:0]  NPAIR = 8'(NCOEF / 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic [87:0] buf_q;
    logic [6:0]  fill_q;
    logic [5:0]  words_q;
    logic [7:0]  pairs_q;
    logic [3:0]  l_q;
    logic [23:0] coeffs_q;
    logic        cvalid_q;
    logic        done_q;

    function automatic logic l_legal(input logic [3:0] l);
        return (l == 4'd1) || (l == 4'd4) || (l == 4'd5) ||
               (l == 4'd10) || (l == 4'd11) || (l == 4'd12);
    endfunction

    function automatic logic [11:0] reduce_q(input logic [11:0] c, input logic is12);
        return (is12 && c >= Q) ? c - Q : c;
    endfunction

    logic [6:0]  two_l;
    logic [5:0]  words_max;
    logic        ready;
    logic        word_fire;
    logic        take;
    logic        load;
    logic [12:0] mask13;
    logic [87:0] shifted_l;
    logic [11:0] c0;
    logic [11:0] c1;
    logic [87:0] buf_pop;
    logic [6:0]  fill_pop;
    logic [87:0] buf_d;
    logic [6:0]  fill_d;

    assign two_l     = {2'b00, l_q, 1'b0};
    assign words_max = {l_q, 2'b00};

    // Ready is masked during reset so nothing is offered while the block is being cleared.
    always_comb begin
        ready = 1'b0;
        if (!i_rst) begin
            case (state_q)
                S_IDLE:  ready = l_legal(bus.i_l);
                S_RUN:   ready = (fill_q < two_l) && (words_q < words_max);
                default: ready = 1'b0;
            endcase
        end
    end

    assign word_fire = bus.i_ibytes_valid & ready;
    assign take      = cvalid_q & bus.i_coeffs_ready;
    assign load      = (state_q == S_RUN) && (!cvalid_q || take) &&
                       (fill_q >= two_l) && (pairs_q < NPAIR);

    assign mask13    = (13'd1 << l_q) - 13'd1;
    assign shifted_l = buf_q >> l_q;
    assign c0        = reduce_q(buf_q[11:0] & mask13[11:0], l_q == 4'd12);
    assign c1        = reduce_q(shifted_l[11:0] & mask13[11:0], l_q == 4'd12);

    // Pop happens before the append so a same-cycle push lands right after the surviving bits.
    assign buf_pop  = load ? (buf_q >> two_l) : buf_q;
    assign fill_pop = load ? (fill_q - two_l) : fill_q;
    assign buf_d    = word_fire ? (buf_pop | ({24'd0, bus.i_ibytes} << fill_pop)) : buf_pop;
    assign fill_d   = word_fire ? (fill_pop + 7'd64) : fill_pop;

`ifdef DECODE_DEBUG_EN
    logic [3071:0] dbg_q;
    assign o_coeffs_debug = dbg_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            fill_q   <= '0;
            words_q  <= '0;
            pairs_q  <= '0;
            l_q      <= '0;
            coeffs_q <= '0;
            cvalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef DECODE_DEBUG_EN
            dbg_q    <= '0;
`endif
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (word_fire) begin
                        l_q     <= bus.i_l;
                        words_q <= 6'd1;
                        pairs_q <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (word_fire) words_q <= words_q + 6'd1;
                    if (load) begin
                        coeffs_q <= {c0, c1};
                        cvalid_q <= 1'b1;
                        pairs_q  <= pairs_q + 8'd1;
`ifdef DECODE_DEBUG_EN
                        dbg_q[3071 - 24 * int'(pairs_q) -: 24] <= {c0, c1};
`endif
                    end else if (take) begin
                        cvalid_q <= 1'b0;
                        if (pairs_q == NPAIR) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    words_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ibytes_ready = ready;
    assign bus.o_coeffs       = coeffs_q;
    assign bus.o_coeffs_valid = cvalid_q;
    assign bus.o_done         = done_q;
endmodule
